// File: rtl/uart_parity_pkg.sv
// Shared definitions for the UART parity engine: mode encodings, RX state enum, parity rule.
// Pure declarations; no latency of its own.
// No flow control; the helpers are combinational.
package uart_parity_pkg;

  // Parity mode encodings; 5..7 are treated as no parity.
  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } rx_state_t;

  // Map the XOR of the data bits to the parity bit for a given mode.
  function automatic logic apply_parity_mode(input logic [2:0] mode, input logic xor_bit);
    logic p;
    case (mode)
      PAR_EVEN: p = xor_bit;
      PAR_ODD:  p = ~xor_bit;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;   // space, none and reserved encodings
    endcase
    return p;
  endfunction

  // True when the mode carries a parity bit on the wire.
  function automatic logic parity_enabled(input logic [2:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
           (mode == PAR_MARK) || (mode == PAR_SPACE);
  endfunction

endpackage

// File: rtl/uart_parity_rx_fsm.sv
// RX parity tracker: accumulates serial bits, checks the trailing parity bit.
// frame_done/parity_err register one cycle after the final qualifying bit.
// No backpressure; bit_valid is consumed whenever a frame is open.
module uart_parity_rx_fsm
  import uart_parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic       frame_start,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       busy,
  output logic       frame_done,
  output logic       parity_err,
  output logic       err_event
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  rx_state_t        state;
  logic [2:0]       rx_mode;
  logic             acc;
  logic [CNT_W-1:0] bit_cnt;

  logic data_bit_take;
  logic last_data_bit;
  logic par_bit_take;
  logic mismatch;

  // Qualify the incoming bit; a restart always takes priority over data.
  always_comb begin
    data_bit_take = (state == DATA) && bit_valid && !frame_start;
    last_data_bit = data_bit_take && (bit_cnt == LAST_IDX);
    par_bit_take  = (state == PAR) && bit_valid && !frame_start;
    mismatch      = par_bit_take && (bit_in != apply_parity_mode(rx_mode, acc));
  end

  // Same-edge error indication lets the status counters update with parity_err.
  assign err_event = mismatch && !reset;

  // Frame state machine with registered status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rx_mode    <= PAR_NONE;
      acc        <= 1'b0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      if (frame_start) begin
        // Open or restart a frame; an abandoned frame never reports done.
        state   <= DATA;
        rx_mode <= mode;
        acc     <= 1'b0;
        bit_cnt <= '0;
        busy    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            // Stray bit_valid outside a frame is dropped.
          end
          DATA: begin
            if (data_bit_take) begin
              acc     <= acc ^ bit_in;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (last_data_bit) begin
                if (parity_enabled(rx_mode)) begin
                  state <= PAR;
                end else begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                end
              end
            end
          end
          PAR: begin
            if (par_bit_take) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              parity_err <= mismatch;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_parity_engine.sv
// Parity generator (TX, parallel) and checker (RX, serial) with sticky/counted errors.
// TX parity 1 cycle after parity_load; RX status 1 cycle after the final bit.
// No backpressure; a load is accepted every cycle and RX bits whenever qualified.
module uart_parity_engine
  import uart_parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           mode,
  input  logic [DATA_W-1:0]    parity_data_in,
  input  logic                 parity_load,
  output logic                 parity_out,
  output logic                 parity_valid,
  input  logic                 frame_start,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 err_clear,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  logic err_event;

  uart_parity_rx_fsm #(
    .DATA_W (DATA_W)
  ) u_rx_fsm (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .busy        (busy),
    .frame_done  (frame_done),
    .parity_err  (parity_err),
    .err_event   (err_event)
  );

  // TX parity register: recompute on each load, hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_out   <= 1'b0;
      parity_valid <= 1'b0;
    end else begin
      parity_valid <= parity_load;
      if (parity_load) begin
        parity_out <= apply_parity_mode(mode, ^parity_data_in);
      end
    end
  end

  // Error status; a new error outranks a same-cycle clear and restarts the count at one.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_event) begin
      err_sticky <= 1'b1;
      if (err_clear) begin
        err_count <= CNT_ONE;
      end else if (err_count != CNT_MAX) begin
        err_count <= err_count + CNT_ONE;
      end
    end else if (err_clear) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end
  end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Directed bench: TX parity modes, RX frames (good/bad/none/restart/reset), saturation, 5-bit width.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Two instances: 8-bit data with a 2-bit error counter, and 5-bit data with the default counter.
module tb_uart_parity_engine;
  import uart_parity_pkg::*;

  logic clock;
  logic reset;

  // Instance A: DATA_W=8, ERR_CNT_W=2
  logic [2:0] mode;
  logic [7:0] pdata;
  logic       pload, fstart, bval, bin, eclr;
  logic       pout, pvld, busy, fdone, perr, sticky;
  logic [1:0] ecnt;

  // Instance B: DATA_W=5, ERR_CNT_W=8
  logic [2:0] b_mode;
  logic [4:0] b_pdata;
  logic       b_pload, b_fstart, b_bval, b_bin, b_eclr;
  logic       b_pout, b_pvld, b_busy, b_fdone, b_perr, b_sticky;
  logic [7:0] b_ecnt;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int d0;

  uart_parity_engine #(.DATA_W(8), .ERR_CNT_W(2)) dut_a (
    .clock(clock), .reset(reset), .mode(mode), .parity_data_in(pdata),
    .parity_load(pload), .parity_out(pout), .parity_valid(pvld),
    .frame_start(fstart), .bit_valid(bval), .bit_in(bin), .err_clear(eclr),
    .busy(busy), .frame_done(fdone), .parity_err(perr),
    .err_sticky(sticky), .err_count(ecnt)
  );

  uart_parity_engine #(.DATA_W(5), .ERR_CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .mode(b_mode), .parity_data_in(b_pdata),
    .parity_load(b_pload), .parity_out(b_pout), .parity_valid(b_pvld),
    .frame_start(b_fstart), .bit_valid(b_bval), .bit_in(b_bin), .err_clear(b_eclr),
    .busy(b_busy), .frame_done(b_fdone), .parity_err(b_perr),
    .err_sticky(b_sticky), .err_count(b_ecnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count every cycle in which instance A reports frame_done.
  always @(posedge clock) if (fdone === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_bit(input logic b);
    bval = 1'b1; bin = b;
    tick();
    bval = 1'b0; bin = 1'b0;
  endtask

  task automatic a_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) a_bit(d[i]);
  endtask

  task automatic a_start(input logic [2:0] m);
    mode = m; fstart = 1'b1;
    tick();
    fstart = 1'b0;
  endtask

  // One gapped bit for instance B: two idle cycles after each bit.
  task automatic b_bit(input logic b);
    b_bval = 1'b1; b_bin = b;
    tick();
    b_bval = 1'b0; b_bin = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    mode = PAR_NONE; pdata = '0; pload = 0; fstart = 0; bval = 0; bin = 0; eclr = 0;
    b_mode = PAR_NONE; b_pdata = '0; b_pload = 0; b_fstart = 0; b_bval = 0; b_bin = 0; b_eclr = 0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_pout", pout, 0);
    chk("rst_pvld", pvld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", fdone, 0);
    chk("rst_perr", perr, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_ecnt", ecnt, 0);
    chk("rst_b_busy", b_busy, 0);

    // TX: back-to-back loads of 8'hA5 (four ones) in each mode
    pdata = 8'hA5; pload = 1'b1;
    mode = PAR_EVEN;  tick(); chk("tx_even_a5", pout, 0); chk("tx_even_vld", pvld, 1);
    mode = PAR_ODD;   tick(); chk("tx_odd_a5", pout, 1);  chk("tx_odd_vld", pvld, 1);
    mode = PAR_MARK;  tick(); chk("tx_mark", pout, 1);
    mode = PAR_SPACE; tick(); chk("tx_space", pout, 0);
    pload = 1'b0;     tick(); chk("tx_vld_drop", pvld, 0);
    chk("tx_hold0", pout, 0);
    // Single set bit in even mode, then hold across a mode change without load
    pdata = 8'h01; mode = PAR_EVEN; pload = 1'b1; tick(); chk("tx_even_01", pout, 1);
    pload = 1'b0; mode = PAR_SPACE; tick(); chk("tx_hold1", pout, 1);
    // Reserved mode 5 behaves as none
    pload = 1'b1; mode = 3'd5; tick(); chk("tx_mode5", pout, 0);
    mode = PAR_MARK; tick(); chk("tx_mark2", pout, 1);
    pload = 1'b0; tick();

    // RX odd, 8'h07 (three ones) -> expected parity 0; mode changes mid-frame are ignored
    a_start(PAR_ODD);
    chk("odd_busy", busy, 1);
    mode = PAR_EVEN;
    a_bits(8'h07, 8);
    chk("odd_par_wait_done", fdone, 0);
    chk("odd_par_wait_busy", busy, 1);
    a_bit(1'b0);
    chk("odd_good_done", fdone, 1);
    chk("odd_good_err", perr, 0);
    chk("odd_good_busy", busy, 0);
    tick();
    chk("odd_good_done_pulse", fdone, 0);

    // Same frame with wrong parity bit
    a_start(PAR_ODD);
    a_bits(8'h07, 8);
    a_bit(1'b1);
    chk("odd_bad_done", fdone, 1);
    chk("odd_bad_err", perr, 1);
    chk("odd_bad_sticky", sticky, 1);
    chk("odd_bad_cnt", ecnt, 1);
    tick();
    chk("odd_bad_err_pulse", perr, 0);
    chk("odd_bad_sticky_hold", sticky, 1);

    // Mode none: done straight after the 8th data bit
    a_start(PAR_NONE);
    a_bits(8'h5A, 7);
    chk("none_7_done", fdone, 0);
    chk("none_7_busy", busy, 1);
    a_bit(1'b0);
    chk("none_done", fdone, 1);
    chk("none_busy", busy, 0);
    chk("none_err", perr, 0);
    // A bit in IDLE is ignored
    a_bit(1'b1);
    chk("idle_bit_busy", busy, 0);
    chk("idle_bit_done", fdone, 0);

    // Restart after 4 bits, then a good even frame of 8'hA5 with parity 0
    tick();
    d0 = done_cnt;
    a_start(PAR_EVEN);
    a_bits(8'hFF, 4);
    a_start(PAR_EVEN);
    chk("restart_no_done", fdone, 0);
    chk("restart_busy", busy, 1);
    a_bits(8'hA5, 8);
    a_bit(1'b0);
    chk("restart_done", fdone, 1);
    chk("restart_err", perr, 0);
    chk("restart_cnt", ecnt, 1);
    tick();
    chk("restart_one_done", done_cnt - d0, 1);
    chk("tx_hold_rx", pout, 1);

    // Reset mid-frame
    d0 = done_cnt;
    a_start(PAR_ODD);
    a_bits(8'h07, 3);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", fdone, 0);
    chk("midrst_pout", pout, 0);
    chk("midrst_sticky", sticky, 0);
    chk("midrst_cnt", ecnt, 0);
    tick(); tick();
    chk("midrst_no_done", done_cnt - d0, 0);

    // Five bad even frames (8'h07 needs parity 1, send 0): count saturates at 3
    for (int k = 1; k <= 5; k++) begin
      a_start(PAR_EVEN);
      a_bits(8'h07, 8);
      a_bit(1'b0);
      chk($sformatf("sat_err_%0d", k), perr, 1);
      chk($sformatf("sat_cnt_%0d", k), ecnt, (k > 3) ? 3 : k);
    end
    // Sixth error with a same-cycle clear: error wins
    a_start(PAR_EVEN);
    a_bits(8'h07, 8);
    eclr = 1'b1;
    a_bit(1'b0);
    eclr = 1'b0;
    chk("clr_err_perr", perr, 1);
    chk("clr_err_cnt", ecnt, 1);
    chk("clr_err_sticky", sticky, 1);
    // Plain clear
    eclr = 1'b1; tick(); eclr = 1'b0;
    chk("clr_cnt", ecnt, 0);
    chk("clr_sticky", sticky, 0);

    // Instance B: 5-bit even, 5'b10110 (three ones) -> parity 1, gapped bits
    b_mode = PAR_EVEN; b_fstart = 1'b1; tick(); b_fstart = 1'b0;
    chk("b_busy", b_busy, 1);
    b_bit(1'b0); b_bit(1'b1); b_bit(1'b1); b_bit(1'b0); b_bit(1'b1);
    chk("b_par_wait_done", b_fdone, 0);
    chk("b_par_wait_busy", b_busy, 1);
    b_bval = 1'b1; b_bin = 1'b1; tick(); b_bval = 1'b0;
    chk("b_good_done", b_fdone, 1);
    chk("b_good_err", b_perr, 0);
    chk("b_good_cnt", b_ecnt, 0);
    tick();
    // Same data with parity 0 -> error
    b_fstart = 1'b1; tick(); b_fstart = 1'b0;
    b_bit(1'b0); b_bit(1'b1); b_bit(1'b1); b_bit(1'b0); b_bit(1'b1);
    b_bval = 1'b1; b_bin = 1'b0; tick(); b_bval = 1'b0;
    chk("b_bad_done", b_fdone, 1);
    chk("b_bad_err", b_perr, 1);
    chk("b_bad_cnt", b_ecnt, 1);
    // 5-bit TX: 5'b10110 even -> 1
    b_pdata = 5'b10110; b_pload = 1'b1; tick(); b_pload = 1'b0;
    chk("b_tx_even", b_pout, 1);
    chk("b_tx_vld", b_pvld, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised parity generator/checker for the UART datapath, successor to the fixed 8-bit even-parity generator. It handles configurable data width and five parity modes. On the TX side it produces the parity bit from a parallel word. On the RX side it accumulates parity serially as bits arrive, compares the result against the received parity bit, and keeps sticky and counted error status.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (5..16 legal)
- ERR_CNT_W, 8, width of saturating parity-error counter

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mode  in  3  parity mode: 0 none, 1 even, 2 odd, 3 mark, 4 space; 5..7 treated as none
- parity_data_in  in  DATA_W  TX word for parallel generation
- parity_load  in  1  capture parity_data_in and mode, compute parity
- parity_out  out  1  registered TX parity bit
- parity_valid  out  1  one-cycle pulse, parity_out updated
- frame_start  in  1  begin RX frame; clears accumulator, latches mode
- bit_valid  in  1  qualifies bit_in
- bit_in  in  1  RX serial data bit, then RX parity bit
- err_clear  in  1  clear err_sticky and err_count
- busy  out  1  RX frame in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse at end of RX frame
- parity_err  out  1  one-cycle pulse, coincident with frame_done, on mismatch
- err_sticky  out  1  set on any parity_err
- err_count  out  ERR_CNT_W  saturating count of parity errors

## Operation
- Reset values: parity_out 0, parity_valid 0, busy 0, frame_done 0, parity_err 0, err_sticky 0, err_count 0, state IDLE, accumulator 0, bit count 0.
- Parallel path, independent of the RX FSM. On parity_load, parity_out <= f(mode, ^parity_data_in) and parity_valid pulses. f is defined as follows:
  - even: XOR of the data bits
  - odd: inverted XOR
  - mark: 1
  - space: 0
  - none: 0
- Without parity_load, parity_out holds its value.
- RX FSM states:
  - IDLE: frame_start -> DATA. Clears accumulator and bit count, latches rx_mode.
  - DATA: each bit_valid XORs bit_in into accumulator and increments count. On the DATA_W-th bit: if rx_mode is none, go to IDLE and pulse frame_done; otherwise go to PAR.
  - PAR: the next bit_valid is the received parity bit. Compare it with f(rx_mode, accumulator). Pulse frame_done; pulse parity_err on mismatch. Go to IDLE.
- frame_start in DATA or PAR restarts the frame: accumulator and count are cleared, mode is relatched, and no frame_done is emitted. frame_start wins over a simultaneous bit_valid.
- bit_valid in IDLE is ignored.
- err_count increments on each parity_err and saturates at all-ones.
- err_clear with a simultaneous parity_err: the error wins. err_sticky = 1, err_count = 1.
- Mode changes mid-frame have no effect; rx_mode stays latched until the next frame_start.

## Timing
- parity_load at edge N -> parity_out/parity_valid visible after edge N (1-cycle latency). Back-to-back loads are accepted every cycle.
- The final qualifying bit_valid at edge N -> frame_done/parity_err high for exactly the cycle after edge N. err_sticky/err_count update on the same edge.
- busy rises the cycle after frame_start and falls the same cycle frame_done asserts.
- Minimum frame: DATA_W+1 bit_valid cycles (DATA_W for mode none). bit_valid may be contiguous or gapped.
- reset asserted mid-frame -> IDLE next edge, all outputs at reset values; no frame_done.

## Structure
- Shared package uart_parity_pkg contains:
  - mode encodings PAR_NONE..PAR_SPACE
  - RX state enum (IDLE, DATA, PAR)
  - function apply_parity_mode(mode, xor_bit)
- One sub-module, uart_parity_rx_fsm: RX state machine, accumulator, bit counter, and error pulse.
- The top level holds the TX register and the error status/counter.

## Test plan
- DATA_W=8, mode even, parity_load with 8'hA5 -> parity_out 0, parity_valid 1 for one cycle; mode odd with 8'hA5 -> 1; mode mark -> 1; mode space -> 0.
- Mode odd, frame_start, bits of 8'h07 LSB first, then parity bit 0 -> frame_done pulse, parity_err 0. Repeat with parity bit 1 -> parity_err 1, err_sticky 1, err_count 1.
- Mode none, frame_start, 8 bits -> frame_done after the 8th bit, no PAR state, parity_err 0.
- frame_start after 4 bits, then a full 9-bit good frame -> exactly one frame_done, no error. reset after 3 bits -> busy 0, no frame_done.
- ERR_CNT_W=2, five bad frames -> err_count saturates at 3. err_clear on the same cycle as a 6th error -> err_count 1, err_sticky 1.
- DATA_W=5, mode even, gapped bit_valid (idle cycles between bits), bits 5'b10110 plus parity 1 -> no error.
